// File: rtl/box_overlay_draw_pkg.sv
// Shared types and constants for the box overlay drawing block.
package box_overlay_draw_pkg;

    // Tracking FSM states, one-hot.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_TRACK = 4'b0010,
        ST_COAST = 4'b0100,
        ST_LOST  = 4'b1000
    } state_t;

    localparam logic [23:0] DEF_BOX_COLOR   = 24'hFF0000;
    localparam logic [23:0] DEF_CROSS_COLOR = 24'h00FF00;

endpackage

// File: rtl/box_overlay_draw_box_latch_fsm.sv
// Per-frame box sampler: VS falling-edge detect, box validation, tracking FSM
// with coast counter, and the box/centre registers used by the draw pipeline.
module box_latch_fsm
    import box_overlay_draw_pkg::*;
#(
    parameter int IMG_WIDTH_LINE = 1024,
    parameter int IMG_HEIGHT     = 768,
    parameter int LOST_FRAMES    = 8
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        i_vs,
    input  logic [11:0] hcount_l,
    input  logic [11:0] hcount_r,
    input  logic [11:0] vcount_l,
    input  logic [11:0] vcount_r,
    output logic [11:0] box_l,
    output logic [11:0] box_r,
    output logic [11:0] box_t,
    output logic [11:0] box_b,
    output logic [11:0] center_x,
    output logic [11:0] center_y,
    output logic        box_valid
);
    localparam logic [12:0] X_LIM    = 13'(IMG_WIDTH_LINE);
    localparam logic [12:0] Y_LIM    = 13'(IMG_HEIGHT);
    localparam logic [3:0]  LOST_MAX = 4'(LOST_FRAMES);

    state_t      state;
    logic        vs_r;
    logic [3:0]  lost_cnt;
    logic        vs_fall;
    logic        box_ok;
    logic [12:0] sum_x;
    logic [12:0] sum_y;
    logic [3:0]  lost_nxt;

    // Frame-boundary detect, box validation, centre sums and saturating miss count.
    always_comb begin
        vs_fall  = ~i_vs & vs_r;
        box_ok   = (hcount_l < hcount_r) && (vcount_l < vcount_r) &&
                   ({1'b0, hcount_r} < X_LIM) && ({1'b0, vcount_r} < Y_LIM);
        sum_x    = {1'b0, hcount_l} + {1'b0, hcount_r};
        sum_y    = {1'b0, vcount_l} + {1'b0, vcount_r};
        lost_nxt = (lost_cnt == 4'hF) ? lost_cnt : lost_cnt + 4'd1;
    end

    // Tracking FSM; box and centre only change at a VS falling edge.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            vs_r      <= 1'b0;
            lost_cnt  <= 4'd0;
            box_l     <= 12'd0;
            box_r     <= 12'd0;
            box_t     <= 12'd0;
            box_b     <= 12'd0;
            center_x  <= 12'd0;
            center_y  <= 12'd0;
            box_valid <= 1'b0;
        end else if (en) begin
            vs_r <= i_vs;
            if (vs_fall) begin
                if (box_ok) begin
                    box_l     <= hcount_l;
                    box_r     <= hcount_r;
                    box_t     <= vcount_l;
                    box_b     <= vcount_r;
                    center_x  <= sum_x[12:1];
                    center_y  <= sum_y[12:1];
                    state     <= ST_TRACK;
                    lost_cnt  <= 4'd0;
                    box_valid <= 1'b1;
                end else begin
                    case (state)
                        ST_TRACK: begin
                            lost_cnt <= 4'd1;
                            // A loss budget of one frame skips coasting entirely.
                            if (LOST_MAX <= 4'd1) begin
                                state     <= ST_LOST;
                                box_valid <= 1'b0;
                            end else begin
                                state <= ST_COAST;
                            end
                        end
                        ST_COAST: begin
                            lost_cnt <= lost_nxt;
                            if (lost_nxt >= LOST_MAX) begin
                                state     <= ST_LOST;
                                box_valid <= 1'b0;
                            end
                        end
                        ST_LOST:  lost_cnt <= lost_nxt;
                        default:  ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/box_overlay_draw.sv
// Box overlay: draws the tracked bounding box and a centre crosshair onto the
// live RGB stream through a two-stage pipeline (compare flags, colour mux).
module box_overlay_draw
    import box_overlay_draw_pkg::*;
#(
    parameter int          IMG_WIDTH_LINE = 1024,
    parameter int          IMG_HEIGHT     = 768,
    parameter int          LINE_W         = 2,
    parameter logic [23:0] BOX_COLOR      = DEF_BOX_COLOR,
    parameter logic [23:0] CROSS_COLOR    = DEF_CROSS_COLOR,
    parameter int          CROSS_LEN      = 4,
    parameter int          LOST_FRAMES    = 8
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [23:0] i_rgb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_hcount,
    input  logic [11:0] i_vcount,
    input  logic [11:0] hcount_l,
    input  logic [11:0] hcount_r,
    input  logic [11:0] vcount_l,
    input  logic [11:0] vcount_r,
    output logic [23:0] o_rgb,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_center_x,
    output logic [11:0] o_center_y,
    output logic        o_box_valid
);
    localparam logic [12:0] LW_M1 = 13'(LINE_W - 1);
    localparam logic [12:0] CLEN  = 13'(CROSS_LEN);

    logic [11:0] box_l, box_r, box_t, box_b, cx, cy;
    logic        box_valid;

    box_latch_fsm #(
        .IMG_WIDTH_LINE (IMG_WIDTH_LINE),
        .IMG_HEIGHT     (IMG_HEIGHT),
        .LOST_FRAMES    (LOST_FRAMES)
    ) u_latch (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .en        (en),
        .i_vs      (i_vs),
        .hcount_l  (hcount_l),
        .hcount_r  (hcount_r),
        .vcount_l  (vcount_l),
        .vcount_r  (vcount_r),
        .box_l     (box_l),
        .box_r     (box_r),
        .box_t     (box_t),
        .box_b     (box_b),
        .center_x  (cx),
        .center_y  (cy),
        .box_valid (box_valid)
    );

    assign o_center_x  = cx;
    assign o_center_y  = cy;
    assign o_box_valid = box_valid;

    logic [12:0]        x13, y13, l13, r13, t13, b13, cx13, cy13;
    logic signed [12:0] dx, dy;
    logic [12:0]        adx, ady;
    logic               in_box, in_band, border_hit, cross_hit;

    // Pixel classification; 13-bit math so band edges and deltas never wrap.
    always_comb begin
        x13  = {1'b0, i_hcount};
        y13  = {1'b0, i_vcount};
        l13  = {1'b0, box_l};
        r13  = {1'b0, box_r};
        t13  = {1'b0, box_t};
        b13  = {1'b0, box_b};
        cx13 = {1'b0, cx};
        cy13 = {1'b0, cy};
        dx   = $signed(x13) - $signed(cx13);
        dy   = $signed(y13) - $signed(cy13);
        adx  = dx[12] ? 13'(-dx) : 13'(dx);
        ady  = dy[12] ? 13'(-dy) : 13'(dy);
        // Bands are tested inside the box only, so they clip at its edges.
        in_box  = (x13 >= l13) && (x13 <= r13) && (y13 >= t13) && (y13 <= b13);
        in_band = (y13 <= t13 + LW_M1) || (y13 + LW_M1 >= b13) ||
                  (x13 <= l13 + LW_M1) || (x13 + LW_M1 >= r13);
        border_hit = box_valid && i_de && in_box && in_band;
        cross_hit  = box_valid && i_de &&
                     (((y13 == cy13) && (adx <= CLEN)) || ((x13 == cx13) && (ady <= CLEN)));
    end

    logic [23:0] s1_rgb;
    logic        s1_hs, s1_vs, s1_de, s1_border, s1_cross;

    // Stage 1: register hit flags alongside the delayed video.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_rgb    <= 24'd0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_border <= 1'b0;
            s1_cross  <= 1'b0;
        end else if (en) begin
            s1_rgb    <= i_rgb;
            s1_hs     <= i_hs;
            s1_vs     <= i_vs;
            s1_de     <= i_de;
            s1_border <= border_hit;
            s1_cross  <= cross_hit;
        end
    end

    // Stage 2: colour mux, crosshair over border over live video.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_rgb <= 24'd0;
            o_hs  <= 1'b0;
            o_vs  <= 1'b0;
            o_de  <= 1'b0;
        end else if (en) begin
            o_rgb <= s1_cross ? CROSS_COLOR : (s1_border ? BOX_COLOR : s1_rgb);
            o_hs  <= s1_hs;
            o_vs  <= s1_vs;
            o_de  <= s1_de;
        end
    end

endmodule

// File: tb/tb_box_overlay_draw.sv
// Randomised self-checking bench for box_overlay_draw with a behavioural model.
module tb_box_overlay_draw;
    localparam int          LW     = 2;
    localparam int          CL     = 4;
    localparam int          LF     = 8;
    localparam logic [23:0] BOXC   = 24'hFF0000;
    localparam logic [23:0] CROSSC = 24'h00FF00;

    logic        pixelclk = 1'b0;
    logic        reset_n  = 1'b0;
    logic        en       = 1'b1;
    logic [23:0] i_rgb    = '0;
    logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
    logic [11:0] i_hcount = '0, i_vcount = '0;
    logic [11:0] hcount_l = '0, hcount_r = '0, vcount_l = '0, vcount_r = '0;
    logic [23:0] o_rgb;
    logic        o_hs, o_vs, o_de, o_box_valid;
    logic [11:0] o_center_x, o_center_y;

    always #5 pixelclk = ~pixelclk;

    box_overlay_draw dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .en(en),
        .i_rgb(i_rgb), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .i_hcount(i_hcount), .i_vcount(i_vcount),
        .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
        .o_rgb(o_rgb), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_center_x(o_center_x), .o_center_y(o_center_y), .o_box_valid(o_box_valid)
    );

    int n_assert = 0, n_fail = 0;
    bit chk_on = 0, counting = 0;
    int nbox = 0, ncross = 0;

    // ---------------- behavioural model ----------------
    int  ml = 0, mr = 0, mt = 0, mb = 0, mcx = 0, mcy = 0, miss = 0;
    bit  seen = 0, mvs = 0;
    logic [23:0] q_rgb [2];
    logic        q_hs [2], q_vs [2], q_de [2];

    function automatic bit active();
        return seen && (miss < LF);
    endfunction

    function automatic logic [23:0] pix(int x, int y, logic [23:0] rgb, logic de, bit on,
                                        int l, int r, int t, int b, int cx, int cy);
        int dx, dy;
        dx = (x > cx) ? x - cx : cx - x;
        dy = (y > cy) ? y - cy : cy - y;
        if (!de || !on) return rgb;
        if ((y == cy && dx <= CL) || (x == cx && dy <= CL)) return CROSSC;
        if (x >= l && x <= r && y >= t && y <= b &&
            (y - t < LW || b - y < LW || x - l < LW || r - x < LW)) return BOXC;
        return rgb;
    endfunction

    always @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                q_rgb[i] = '0; q_hs[i] = 0; q_vs[i] = 0; q_de[i] = 0;
            end
            seen = 0; miss = 0; mvs = 0;
            ml = 0; mr = 0; mt = 0; mb = 0; mcx = 0; mcy = 0;
        end else if (en) begin
            q_rgb[1] = q_rgb[0]; q_hs[1] = q_hs[0]; q_vs[1] = q_vs[0]; q_de[1] = q_de[0];
            q_rgb[0] = pix(int'(i_hcount), int'(i_vcount), i_rgb, i_de, active(),
                           ml, mr, mt, mb, mcx, mcy);
            q_hs[0] = i_hs; q_vs[0] = i_vs; q_de[0] = i_de;
            if (mvs && !i_vs) begin
                if (hcount_l < hcount_r && vcount_l < vcount_r &&
                    int'(hcount_r) < 1024 && int'(vcount_r) < 768) begin
                    ml = hcount_l; mr = hcount_r; mt = vcount_l; mb = vcount_r;
                    mcx = (ml + mr) / 2; mcy = (mt + mb) / 2;
                    seen = 1; miss = 0;
                end else if (seen && miss < 15) begin
                    miss++;
                end
            end
            mvs = i_vs;
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge pixelclk) begin
        if (chk_on) begin
            n_assert++;
            if (o_rgb !== q_rgb[1] || o_hs !== q_hs[1] || o_vs !== q_vs[1] || o_de !== q_de[1] ||
                o_box_valid !== active() || o_center_x !== 12'(mcx) || o_center_y !== 12'(mcy)) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got rgb=%h hs=%b vs=%b de=%b bv=%b c=(%0d,%0d) want rgb=%h hs=%b vs=%b de=%b bv=%b c=(%0d,%0d)",
                         $time, o_rgb, o_hs, o_vs, o_de, o_box_valid, o_center_x, o_center_y,
                         q_rgb[1], q_hs[1], q_vs[1], q_de[1], active(), mcx, mcy);
            end
            if (counting && o_de) begin
                if (o_rgb == BOXC)   nbox++;
                if (o_rgb == CROSSC) ncross++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge pixelclk);
    endtask

    // VS pulse carrying the box coordinates; coords are scrambled once sampled.
    task automatic vsync(input int l, input int r, input int t, input int b);
        i_de = 0; i_hs = 0;
        hcount_l = 12'(l); hcount_r = 12'(r); vcount_l = 12'(t); vcount_r = 12'(b);
        i_vs = 1; repeat (3) tick();
        i_vs = 0; repeat (3) tick();
        hcount_l = 12'($urandom); hcount_r = 12'($urandom);
        vcount_l = 12'($urandom); vcount_r = 12'($urandom);
    endtask

    // One active line x0..x1 at row y; optional 10-cycle en stall before pixel stall_at.
    task automatic line(input int y, input int x0, input int x1, input bit rnd, input int stall_at);
        i_vcount = 12'(y);
        for (int x = x0; x <= x1; x++) begin
            if (x == stall_at) begin
                en = 0;
                repeat (10) begin
                    i_rgb = 24'($urandom); i_hcount = 12'($urandom); i_de = 1'($urandom);
                    tick();
                end
                en = 1; i_vcount = 12'(y);
            end
            i_de = 1; i_hs = 0; i_hcount = 12'(x);
            i_rgb = rnd ? 24'($urandom) : 24'd0;
            tick();
        end
        i_de = 0; i_hs = 1; i_rgb = rnd ? 24'($urandom) : 24'd0;
        repeat (3) tick();
        i_hs = 0; tick();
    endtask

    initial begin
        int l, r, t, b, y0, y1, x0, x1, sl;
        // Model pins from hand-worked pixels of box (100,200,50,150), centre (150,100).
        chk("pin_cross", 32'(pix(150, 100, 24'h0, 1, 1, 100, 200, 50, 150, 150, 100)), 32'h00FF00);
        chk("pin_border", 32'(pix(101, 120, 24'h0, 1, 1, 100, 200, 50, 150, 150, 100)), 32'hFF0000);
        chk("pin_inside", 32'(pix(102, 120, 24'h5, 1, 1, 100, 200, 50, 150, 150, 100)), 32'h5);
        chk("pin_outside", 32'(pix(99, 50, 24'h7, 1, 1, 100, 200, 50, 150, 150, 100)), 32'h7);

        // Reset state
        repeat (4) tick();
        chk("rst_rgb", 32'(o_rgb), 0);
        chk("rst_bv", 32'(o_box_valid), 0);
        chk("rst_cx", 32'(o_center_x), 0);
        chk("rst_sync", {29'd0, o_hs, o_vs, o_de}, 0);
        reset_n = 1; chk_on = 1;
        repeat (3) tick();

        // 1: full box window with black video
        vsync(100, 200, 50, 150);
        counting = 1;
        for (int y = 48; y <= 152; y++) line(y, 98, 202, 0, -1);
        repeat (3) tick();
        counting = 0;
        chk("t1_nbox", nbox, 792);
        chk("t1_ncross", ncross, 17);
        chk("t1_bv", 32'(o_box_valid), 1);
        chk("t1_cx", 32'(o_center_x), 150);
        chk("t1_cy", 32'(o_center_y), 100);
        i_vcount = 12'd50; i_hcount = 12'd100; i_rgb = 24'd0; i_de = 1;
        tick();
        chk("t1_lat1_de", 32'(o_de), 0);
        i_de = 0;
        tick();
        chk("t1_lat2_rgb", 32'(o_rgb), 32'hFF0000);
        chk("t1_lat2_de", 32'(o_de), 1);
        repeat (2) tick();

        // 2: coast for 7 invalid frames, drop on the 8th
        for (int f = 1; f <= 8; f++) begin
            vsync(120, 120, 50, 150);
            line(50, 98, 202, 1, -1);
            line(100, 140, 160, 1, -1);
            if (f == 7) chk("t2_coast_bv", 32'(o_box_valid), 1);
        end
        chk("t2_lost_bv", 32'(o_box_valid), 0);
        chk("t2_cx", 32'(o_center_x), 150);
        chk("t2_cy", 32'(o_center_y), 100);

        // 3: reacquire, coast once, then switch box from COAST
        vsync(100, 200, 50, 150);
        vsync(5, 3, 50, 150);
        line(10, 295, 405, 1, -1);
        vsync(300, 400, 10, 20);
        chk("t3_bv", 32'(o_box_valid), 1);
        chk("t3_cx", 32'(o_center_x), 350);
        chk("t3_cy", 32'(o_center_y), 15);
        for (int y = 9; y <= 21; y++) line(y, 296, 404, 1, -1);

        // 4: box at the image edges, then an out-of-range right edge
        vsync(1000, 1023, 760, 767);
        for (int y = 758; y <= 767; y++) line(y, 990, 1023, 1, -1);
        line(763, 0, 8, 1, -1);
        vsync(1000, 1024, 760, 767);
        chk("t4_rej_cx", 32'(o_center_x), 1011);
        chk("t4_rej_cy", 32'(o_center_y), 763);
        chk("t4_rej_bv", 32'(o_box_valid), 1);
        line(767, 1005, 1023, 1, -1);
        vsync(0, 10, 0, 10);
        for (int y = 0; y <= 11; y++) line(y, 0, 12, 1, -1);
        line(767, 0, 6, 1, -1);

        // 5: randomised boxes and lines with en stalls mid-line
        repeat (16) begin
            l = $urandom_range(0, 1000);
            r = l + $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) r = l;
            t = $urandom_range(0, 740);
            b = t + $urandom_range(1, 30);
            vsync(l, r, t, b);
            y0 = (mt > 2) ? mt - 2 : 0;
            y1 = (mb + 2 < 767) ? mb + 2 : 767;
            x0 = (ml > 3) ? ml - 3 : 0;
            x1 = (mr + 3 < 1023) ? mr + 3 : 1023;
            sl = $urandom_range(x0, x1);
            line(mcy, x0, x1, 1, sl);
            repeat (3) line($urandom_range(y0, y1), x0, x1, 1, -1);
            line(mt, x0, x1, 1, $urandom_range(x0, x1));
        end

        // 6: async reset mid-frame
        vsync(100, 200, 50, 150);
        line(50, 98, 130, 1, -1);
        i_vcount = 12'd51; i_de = 1; i_hcount = 12'd100; i_rgb = 24'($urandom);
        tick();
        i_hcount = 12'd101;
        tick();
        #2 reset_n = 0;
        tick();
        chk("t6_rgb", 32'(o_rgb), 0);
        chk("t6_bv", 32'(o_box_valid), 0);
        chk("t6_de", 32'(o_de), 0);
        reset_n = 1;
        line(52, 98, 202, 1, -1);
        line(100, 140, 160, 1, -1);
        chk("t6_idle_bv", 32'(o_box_valid), 0);
        vsync(100, 200, 50, 150);
        line(50, 98, 202, 1, -1);
        chk("t6_reacq_bv", 32'(o_box_valid), 1);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
